// File: rtl/writeback_multi_pkg.sv
// Shared types for the multi-channel writeback stage: FSM states and the
// commit record carried through the commit FIFO.
package writeback_multi_pkg;

  localparam int CSR_ADDR_W = 12;
  // Record fields are sized for the widest supported datapath; narrower
  // XLEN builds zero-extend on push and slice on pop.
  localparam int XLEN_MAX   = 64;

  typedef enum logic [1:0] {IDLE, WRITE, COMMIT, STALL} wb_state_e;

  typedef struct packed {
    logic                is_wb;
    logic                is_mem;
    logic [4:0]          wd;
    logic [XLEN_MAX-1:0] wdata;
    logic [XLEN_MAX-1:0] instr_addr;
    logic [31:0]         instr;
    logic [XLEN_MAX-1:0] mem_addr;
  } commit_rec_t;

endpackage

// File: rtl/writeback_multi_commit_fifo.sv
// Commit-record FIFO. Push is honoured when not full or when a pop frees the
// slot in the same cycle; head is read straight from the storage flops.
module commit_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem_q [DEPTH];
  T               mem_d [DEPTH];
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/writeback_multi.sv
// Writeback stage: accept one retiring instruction, pulse GPR/CSR/priv writes
// for one cycle, then queue a commit record for the difftest consumer.
module writeback_multi
  import writeback_multi_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NUM_CSR      = 3,
  parameter int COMMIT_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_is_wb,
  input  logic                            in_is_mem_read,
  input  logic                            in_is_jump,
  input  logic                            in_is_mem,
  input  logic [4:0]                      in_wd,
  input  logic [XLEN-1:0]                 in_alu_out,
  input  logic [XLEN-1:0]                 in_mem_out,
  input  logic [XLEN-1:0]                 in_pc_plus4,
  input  logic [XLEN-1:0]                 in_mem_addr,
  input  logic [XLEN-1:0]                 in_instr_addr,
  input  logic [31:0]                     in_instr,
  input  logic [NUM_CSR-1:0]              in_csr_we,
  input  logic [NUM_CSR*CSR_ADDR_W-1:0]   in_csr_addr,
  input  logic [NUM_CSR*XLEN-1:0]         in_csr_value,
  input  logic                            in_priv_we,
  input  logic [1:0]                      in_priv,
  output logic                            wb_en,
  output logic [4:0]                      wd,
  output logic [XLEN-1:0]                 wb_data,
  output logic [NUM_CSR-1:0]              csr_we,
  output logic [NUM_CSR*CSR_ADDR_W-1:0]   csr_addr,
  output logic [NUM_CSR*XLEN-1:0]         csr_value,
  output logic                            priv_we,
  output logic [1:0]                      priv_mode,
  output logic                            commit_valid,
  input  logic                            commit_ready,
  output logic                            commit_is_wb,
  output logic                            commit_is_mem,
  output logic [4:0]                      commit_wd,
  output logic [XLEN-1:0]                 commit_wdata,
  output logic [XLEN-1:0]                 commit_instr_addr,
  output logic [XLEN-1:0]                 commit_mem_addr,
  output logic [31:0]                     commit_instr,
  output logic [$clog2(COMMIT_DEPTH+1)-1:0] commit_count
);

  typedef struct packed {
    logic                          wen;
    logic                          is_mem;
    logic [4:0]                    wd;
    logic [XLEN-1:0]               wb_data;
    logic [XLEN-1:0]               instr_addr;
    logic [XLEN-1:0]               mem_addr;
    logic [31:0]                   instr;
    logic [NUM_CSR-1:0]            csr_we;
    logic [NUM_CSR*CSR_ADDR_W-1:0] csr_addr;
    logic [NUM_CSR*XLEN-1:0]       csr_value;
    logic                          priv_we;
    logic [1:0]                    priv;
  } ins_t;

  wb_state_e   state_q, state_d;
  ins_t        ins_q, ins_d;
  commit_rec_t rec, head;
  logic        push, pop, full, empty, can_push, write_act;

  assign pop      = commit_valid & commit_ready;
  assign can_push = ~full | pop;

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (in_valid && !flush) begin
        // Result mux is resolved at accept so WRITE only has to pulse strobes.
        ins_d.wen        = (in_is_wb | in_is_jump) & (in_wd != 5'd0);
        ins_d.is_mem     = in_is_mem;
        ins_d.wd         = in_wd;
        ins_d.wb_data    = in_is_mem_read ? in_mem_out :
                           in_is_jump     ? in_pc_plus4 : in_alu_out;
        ins_d.instr_addr = in_instr_addr;
        ins_d.mem_addr   = in_mem_addr;
        ins_d.instr      = in_instr;
        ins_d.csr_we     = in_csr_we;
        ins_d.csr_addr   = in_csr_addr;
        ins_d.csr_value  = in_csr_value;
        ins_d.priv_we    = in_priv_we;
        ins_d.priv       = in_priv;
        state_d          = WRITE;
      end
      WRITE:  state_d = flush ? IDLE : COMMIT;
      COMMIT, STALL: begin
        if (can_push) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = STALL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign write_act = (state_q == WRITE) & ~flush;
  assign wb_en     = write_act & ins_q.wen;
  assign csr_we    = write_act ? ins_q.csr_we : '0;
  assign priv_we   = write_act & ins_q.priv_we;
  assign wd        = ins_q.wd;
  assign wb_data   = ins_q.wb_data;
  assign csr_addr  = ins_q.csr_addr;
  assign csr_value = ins_q.csr_value;
  assign priv_mode = ins_q.priv;

  assign rec = '{is_wb:      ins_q.wen,
                 is_mem:     ins_q.is_mem,
                 wd:         ins_q.wd,
                 wdata:      XLEN_MAX'(ins_q.wb_data),
                 instr_addr: XLEN_MAX'(ins_q.instr_addr),
                 instr:      ins_q.instr,
                 mem_addr:   XLEN_MAX'(ins_q.mem_addr)};

  commit_fifo #(.DEPTH(COMMIT_DEPTH), .T(commit_rec_t)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (commit_count)
  );

  assign commit_valid      = ~empty;
  assign commit_is_wb      = head.is_wb;
  assign commit_is_mem     = head.is_mem;
  assign commit_wd         = head.wd;
  assign commit_wdata      = head.wdata[XLEN-1:0];
  assign commit_instr_addr = head.instr_addr[XLEN-1:0];
  assign commit_mem_addr   = head.mem_addr[XLEN-1:0];
  assign commit_instr      = head.instr;

endmodule

// File: tb/tb_writeback_multi.sv
// Scoreboard bench for writeback_multi: directed instructions push expected
// strobe/commit records; a negedge monitor pops and compares them.
module tb_writeback_multi;
  import writeback_multi_pkg::*;

  localparam int XLEN = 64;
  localparam int NC   = 3;
  localparam int DEP  = 4;

  logic clk, rst, flush, in_valid, in_ready;
  logic in_is_wb, in_is_mem_read, in_is_jump, in_is_mem;
  logic [4:0] in_wd;
  logic [XLEN-1:0] in_alu_out, in_mem_out, in_pc_plus4, in_mem_addr, in_instr_addr;
  logic [31:0] in_instr;
  logic [NC-1:0] in_csr_we;
  logic [NC*12-1:0] in_csr_addr;
  logic [NC*XLEN-1:0] in_csr_value;
  logic in_priv_we;
  logic [1:0] in_priv;
  logic wb_en;
  logic [4:0] wd;
  logic [XLEN-1:0] wb_data;
  logic [NC-1:0] csr_we;
  logic [NC*12-1:0] csr_addr;
  logic [NC*XLEN-1:0] csr_value;
  logic priv_we;
  logic [1:0] priv_mode;
  logic commit_valid, commit_ready, commit_is_wb, commit_is_mem;
  logic [4:0] commit_wd;
  logic [XLEN-1:0] commit_wdata, commit_instr_addr, commit_mem_addr;
  logic [31:0] commit_instr;
  logic [$clog2(DEP+1)-1:0] commit_count;

  writeback_multi #(.XLEN(XLEN), .NUM_CSR(NC), .COMMIT_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_wb(in_is_wb), .in_is_mem_read(in_is_mem_read), .in_is_jump(in_is_jump),
    .in_is_mem(in_is_mem), .in_wd(in_wd), .in_alu_out(in_alu_out),
    .in_mem_out(in_mem_out), .in_pc_plus4(in_pc_plus4), .in_mem_addr(in_mem_addr),
    .in_instr_addr(in_instr_addr), .in_instr(in_instr), .in_csr_we(in_csr_we),
    .in_csr_addr(in_csr_addr), .in_csr_value(in_csr_value), .in_priv_we(in_priv_we),
    .in_priv(in_priv), .wb_en(wb_en), .wd(wd), .wb_data(wb_data), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_value(csr_value), .priv_we(priv_we),
    .priv_mode(priv_mode), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_is_wb(commit_is_wb), .commit_is_mem(commit_is_mem),
    .commit_wd(commit_wd), .commit_wdata(commit_wdata),
    .commit_instr_addr(commit_instr_addr), .commit_mem_addr(commit_mem_addr),
    .commit_instr(commit_instr), .commit_count(commit_count)
  );

  typedef struct packed {
    logic wb_en; logic [4:0] wd; logic [63:0] wb_data; logic [2:0] csr_we;
    logic [35:0] csr_addr; logic [191:0] csr_value; logic priv_we; logic [1:0] priv_mode;
  } strobe_t;
  typedef struct packed {
    logic is_wb; logic is_mem; logic [4:0] wd; logic [63:0] wdata;
    logic [63:0] instr_addr; logic [31:0] instr; logic [63:0] mem_addr;
  } commit_t;

  strobe_t exp_s[$];
  commit_t exp_c[$];
  strobe_t act_s, e_s;
  commit_t act_c, e_c;
  int n_cmp = 0, n_err = 0, seq = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_en || (|csr_we) || priv_we) begin
        act_s = {wb_en, wd, wb_data, csr_we, csr_addr, csr_value, priv_we, priv_mode};
        n_cmp++;
        if (exp_s.size() == 0) begin
          n_err++;
          $display("FAIL strobe: got unexpected %h, expected none", act_s);
        end else begin
          e_s = exp_s.pop_front();
          if (act_s !== e_s) begin
            n_err++;
            $display("FAIL strobe: got %h expected %h", act_s, e_s);
          end
        end
      end
      if (commit_valid && commit_ready) begin
        act_c = {commit_is_wb, commit_is_mem, commit_wd, commit_wdata,
                 commit_instr_addr, commit_instr, commit_mem_addr};
        n_cmp++;
        if (exp_c.size() == 0) begin
          n_err++;
          $display("FAIL commit: got unexpected %h, expected none", act_c);
        end else begin
          e_c = exp_c.pop_front();
          if (act_c !== e_c) begin
            n_err++;
            $display("FAIL commit: got %h expected %h", act_c, e_c);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
  // (or one cycle later if fl_write flushes the WRITE cycle).
  task automatic issue(input logic wb, input logic mr, input logic jmp, input logic mm,
                       input logic [4:0] d, input logic [63:0] alu, input logic [63:0] mo,
                       input logic [63:0] pc4, input logic [2:0] cwe, input logic pwe,
                       input logic [1:0] pr, input logic exp_wen,
                       input logic [63:0] exp_data, input logic fl_write);
    int t = 0;
    logic [63:0] ia, ma;
    logic [31:0] ins;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    ia = 64'h1000 + 64'(seq) * 64'd4;
    ma = 64'h2000 + 64'(seq);
    ins = 32'h13 + 32'(seq);
    seq++;
    in_valid = 1'b1; in_is_wb = wb; in_is_mem_read = mr; in_is_jump = jmp;
    in_is_mem = mm; in_wd = d; in_alu_out = alu; in_mem_out = mo; in_pc_plus4 = pc4;
    in_instr_addr = ia; in_mem_addr = ma; in_instr = ins; in_csr_we = cwe;
    in_priv_we = pwe; in_priv = pr;
    if (!fl_write) begin
      if (exp_wen || (|cwe) || pwe)
        exp_s.push_back({exp_wen, d, exp_data, cwe, in_csr_addr, in_csr_value, pwe, pr});
      exp_c.push_back({exp_wen, mm, d, exp_data, ia, ins, ma});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (fl_write) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    commit_ready = 1'b1;
    while ((commit_count != 0 || !in_ready) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_count", 64'(commit_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; commit_ready = 1'b1;
    in_is_wb = 1'b0; in_is_mem_read = 1'b0; in_is_jump = 1'b0; in_is_mem = 1'b0;
    in_wd = '0; in_alu_out = '0; in_mem_out = '0; in_pc_plus4 = '0;
    in_mem_addr = '0; in_instr_addr = '0; in_instr = '0; in_csr_we = '0;
    in_priv_we = 1'b0; in_priv = '0;
    in_csr_addr  = {12'h305, 12'h341, 12'h300};
    in_csr_value = {64'hCCCC, 64'hBBBB, 64'hAAAA};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_count", 64'(commit_count), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU write with cycle-level handshake timing
    issue(1, 0, 0, 0, 5'd5, 64'h1234, 64'h0, 64'h0, 3'b000, 0, 2'd0, 1, 64'h1234, 0);
    chk("alu_rdy_write", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("alu_rdy_commit", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("alu_rdy_back", 64'(in_ready), 64'd1);
    chk("alu_count", 64'(commit_count), 64'd1);

    // Load, jump, x0
    issue(1, 1, 0, 1, 5'd7, 64'h2000, 64'hDEAD, 64'h0, 3'b000, 0, 2'd0, 1, 64'hDEAD, 0);
    issue(0, 0, 1, 0, 5'd1, 64'h55, 64'h0, 64'h80000008, 3'b000, 0, 2'd0, 1, 64'h80000008, 0);
    issue(1, 0, 0, 0, 5'd0, 64'h99, 64'h0, 64'h0, 3'b000, 0, 2'd0, 0, 64'h99, 0);

    // CSR multi-channel plus privilege write
    issue(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 3'b101, 1, 2'd3, 0, 64'h0, 0);
    chk("priv_mode", 64'(priv_mode), 64'd3);
    drain();

    // flush while idle: not accepted
    in_valid = 1'b1; flush = 1'b1; in_is_wb = 1'b1; in_wd = 5'd9;
    @(posedge clk); #1;
    chk("flush_idle_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; flush = 1'b0;

    // flush during WRITE: no strobes, no commit
    issue(1, 0, 0, 0, 5'd6, 64'h66, 64'h0, 64'h0, 3'b011, 1, 2'd1, 1, 64'h66, 1);
    chk("flush_write_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("flush_write_count", 64'(commit_count), 64'd0);

    // backpressure: fill FIFO, fifth stalls; flush in STALL is ignored
    commit_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(1, 0, 0, 0, 5'(10 + i), 64'(256 + i), 64'h0, 64'h0, 3'b000, 0, 2'd0, 1,
            64'(256 + i), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_ready", 64'(in_ready), 64'd0);
    chk("bp_full_count", 64'(commit_count), 64'd4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("bp_flush_stall", 64'(in_ready), 64'd0);
    commit_ready = 1'b1;
    @(posedge clk); #1;
    commit_ready = 1'b0;
    chk("bp_pushpop_count", 64'(commit_count), 64'd4);
    chk("bp_pushpop_idle", 64'(in_ready), 64'd1);
    drain();

    // async reset in STALL
    commit_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(1, 0, 0, 0, 5'(20 + i), 64'(512 + i), 64'h0, 64'h0, 3'b000, 0, 2'd0, 1,
            64'(512 + i), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(commit_count), 64'd0);
    chk("arst_valid", 64'(commit_valid), 64'd0);
    chk("arst_commit_wdata", commit_wdata, 64'd0);
    chk("arst_wb_data", wb_data, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_c.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_count", 64'(commit_count), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    commit_ready = 1'b1;
    issue(1, 0, 0, 0, 5'd3, 64'h77, 64'h0, 64'h0, 3'b000, 0, 2'd0, 1, 64'h77, 0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("strobe_q_left", 64'(exp_s.size()), 64'd0);
    chk("commit_q_left", 64'(exp_c.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
